// File: rtl/interleaved_window_buf.sv
// Ping-pong, multi-channel 2D tile store that returns an I_WIDTH x I_WIDTH window in one access.
// Pixels are spread over I_WIDTH^2 sub-RAMs by (y%I, x%I), so every window touches each sub-RAM exactly once.
module interleaved_window_buf #(
  parameter int I_WIDTH = 2,
  parameter int T_WIDTH = 32,
  parameter int D_SIZE  = 16,
  parameter int N_CH    = 1,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW = $clog2(T_WIDTH)
) (
  input  logic                                        clkb,
  input  logic                                        rst_n,
  input  logic                                        wr_valid,
  output logic                                        wr_ready,
  input  logic [CW-1:0]                               wr_ch,
  input  logic [AW-1:0]                               wr_y,
  input  logic [AW-1:0]                               wr_x,
  input  logic [D_SIZE-1:0]                           wr_data,
  input  logic                                        wr_last,
  input  logic                                        rd_req_valid,
  output logic                                        rd_req_ready,
  input  logic [CW-1:0]                               rd_ch,
  input  logic [AW-1:0]                               rd_y,
  input  logic [AW-1:0]                               rd_x,
  input  logic                                        rd_release,
  output logic                                        rd_valid,
  output logic [I_WIDTH-1:0][I_WIDTH-1:0][D_SIZE-1:0] rd_data,
  output logic [1:0]                                  bank_full
);

  localparam int B_WIDTH = (T_WIDTH + I_WIDTH - 1) / I_WIDTH;
  localparam int DEPTH   = 2 * N_CH * B_WIDTH * B_WIDTH;
  localparam int MW      = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  logic wbank_reg, wbank_next;
  logic rbank_reg, rbank_next;
  logic wr_fire, rd_fire, release_fire;

  assign wr_ready     = ~bank_full[wbank_reg];
  assign rd_req_ready = bank_full[rbank_reg];
  assign wr_fire      = wr_valid & wr_ready;
  assign rd_fire      = rd_req_valid & rd_req_ready;
  assign release_fire = rd_release & bank_full[rbank_reg];

  // The written bank is never full and the released bank always is, so both
  // events can land in the same cycle without touching the same bank.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      bank_state_t state_reg, state_next;

      always_comb begin
        state_next = state_reg;
        if (release_fire && rbank_reg == 1'(gi))
          state_next = EMPTY;
        else if (wr_fire && wbank_reg == 1'(gi))
          state_next = wr_last ? FULL : FILLING;
      end

      always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) state_reg <= EMPTY;
        else        state_reg <= state_next;
      end

      assign bank_full[gi] = (state_reg == FULL);
    end
  endgenerate

  always_comb begin
    wbank_next = wbank_reg ^ (wr_fire & wr_last);
    rbank_next = rbank_reg ^ release_fire;
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      wbank_reg <= 1'b0;
      rbank_reg <= 1'b0;
    end else begin
      wbank_reg <= wbank_next;
      rbank_reg <= rbank_next;
    end
  end

  logic [MW-1:0]     waddr;
  logic [D_SIZE-1:0] ram_q [I_WIDTH][I_WIDTH];

  assign waddr = MW'(((int'(wbank_reg) * N_CH + int'(wr_ch)) * B_WIDTH
                      + int'(wr_y) / I_WIDTH) * B_WIDTH + int'(wr_x) / I_WIDTH);

  generate
    for (gj = 0; gj < I_WIDTH; gj++) begin : g_row
      for (gi = 0; gi < I_WIDTH; gi++) begin : g_col
        logic [D_SIZE-1:0] mem [DEPTH];
        logic [D_SIZE-1:0] q_reg;
        logic [MW-1:0]     raddr;
        logic              wen;
        int                rrow, rcol;

        assign wen  = wr_fire && (int'(wr_y) % I_WIDTH == gj) && (int'(wr_x) % I_WIDTH == gi);
        // Nearest row/column at or after the anchor that lives in this sub-RAM;
        // past the tile edge it is clamped, and the lane is zero-masked later.
        assign rrow = (int'(rd_y) + I_WIDTH - 1 - gj) / I_WIDTH;
        assign rcol = (int'(rd_x) + I_WIDTH - 1 - gi) / I_WIDTH;
        assign raddr = MW'(((int'(rbank_reg) * N_CH + int'(rd_ch)) * B_WIDTH
                            + ((rrow < B_WIDTH) ? rrow : 0)) * B_WIDTH
                           + ((rcol < B_WIDTH) ? rcol : 0));

        always_ff @(posedge clkb) begin
          if (wen)     mem[waddr] <= wr_data;
          if (rd_fire) q_reg      <= mem[raddr];
        end

        assign ram_q[gj][gi] = q_reg;
      end
    end
  endgenerate

  logic                                        s1_valid_reg, s2_valid_reg;
  logic [AW-1:0]                               s1_y_reg, s1_x_reg, s2_y_reg, s2_x_reg;
  logic [I_WIDTH-1:0][I_WIDTH-1:0][D_SIZE-1:0] s2_row_reg;

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_y_reg     <= '0;
      s1_x_reg     <= '0;
    end else begin
      s1_valid_reg <= rd_fire;
      if (rd_fire) begin
        s1_y_reg <= rd_y;
        s1_x_reg <= rd_x;
      end
    end
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_y_reg     <= '0;
      s2_x_reg     <= '0;
      s2_row_reg   <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_y_reg <= s1_y_reg;
        s2_x_reg <= s1_x_reg;
        for (int r = 0; r < I_WIDTH; r++)
          for (int c = 0; c < I_WIDTH; c++)
            s2_row_reg[r][c] <= ram_q[(r + int'(s1_y_reg)) % I_WIDTH][c];
      end
    end
  end

  // Coordinates are compared as ints so an anchor near the edge cannot wrap.
  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s2_valid_reg;
      if (s2_valid_reg) begin
        for (int r = 0; r < I_WIDTH; r++)
          for (int c = 0; c < I_WIDTH; c++)
            if (int'(s2_y_reg) + r >= T_WIDTH || int'(s2_x_reg) + c >= T_WIDTH)
              rd_data[r][c] <= '0;
            else
              rd_data[r][c] <= s2_row_reg[r][(c + int'(s2_x_reg)) % I_WIDTH];
      end
    end
  end

endmodule
